// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding,
// access-length encoding and a helper that turns a length code into a
// byte count.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    // Byte count for a length code; the reserved code 3 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            default:  len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the pipeline requesters, the memory controller and the
// byte-wide RAM. The controller takes the slave view; the environment
// (requesters plus RAM) takes the master view.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();

    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;

    // Load/store port
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    // Byte-wide RAM port (read data valid one cycle after the address)
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_rdata,
        output mem_done, mem_rdata,
        output ram_a, ram_wr, ram_dout
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_rdata,
        input  mem_done, mem_rdata,
        input  ram_a, ram_wr, ram_dout
    );

endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates an instruction-fetch port and a load/store
// port onto a single byte-wide RAM. Multi-byte accesses are serialised one
// byte per cycle, little-endian, with the address wrapping at 2^ADDR_W.
// Load/store wins over fetch when both request in the same cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [2:0]        cnt_q;        // bytes issued/written so far
    logic [2:0]        n_q;          // byte count of current transaction
    logic              owner_mem_q;  // 1: load/store owns it, 0: fetch
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic              ram_wr_q;
    logic [7:0]        ram_dout_q;
    logic              if_done_q;
    logic              mem_done_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;

    logic              accept_d;
    logic              owner_mem_d;
    logic              we_d;
    logic [ADDR_W-1:0] base_d;
    logic [2:0]        n_d;
    logic [1:0]        lane_d;
    logic [1:0]        wr_idx_d;

    // Acceptance mux (load/store has priority) and byte-lane indices.
    always_comb begin
        accept_d    = bus.mem_req | bus.if_req;
        owner_mem_d = bus.mem_req;
        we_d        = bus.mem_req & bus.mem_we;
        base_d      = bus.mem_req ? bus.mem_addr : bus.if_addr;
        n_d         = bus.mem_req ? len_bytes(bus.mem_len) : 3'd4;
        // Read data returned now belongs to the address issued one cycle ago.
        lane_d      = cnt_q[1:0] - 2'd1;
        // Next store byte to put on the RAM bus.
        wr_idx_d    = cnt_q[1:0] + 2'd1;
    end

    // FSM, byte counter, lane assembler and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            owner_mem_q <= 1'b0;
            wdata_q     <= 32'd0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            // Done strobes are single-cycle unless set below.
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        owner_mem_q <= owner_mem_d;
                        n_q         <= n_d;
                        cnt_q       <= 3'd0;
                        wdata_q     <= bus.mem_wdata;
                        ram_a_q     <= base_d;
                        if (we_d) begin
                            state_q    <= ST_WR;
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= bus.mem_wdata[7:0];
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end

                ST_RD: begin
                    // Keep issuing addresses; the one-cycle RAM latency
                    // means the lane captured trails the address by one.
                    ram_a_q <= ram_a_q + ADDR_ONE;
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q != 3'd0) begin
                        if (owner_mem_q) begin
                            if (cnt_q == 3'd1)
                                mem_rdata_q <= {24'd0, bus.ram_din};
                            else
                                mem_rdata_q[{lane_d, 3'b000} +: 8] <= bus.ram_din;
                        end else begin
                            if (cnt_q == 3'd1)
                                if_rdata_q <= {24'd0, bus.ram_din};
                            else
                                if_rdata_q[{lane_d, 3'b000} +: 8] <= bus.ram_din;
                        end
                    end
                    if (cnt_q == n_q) begin
                        state_q    <= ST_DONE;
                        mem_done_q <= owner_mem_q;
                        if_done_q  <= ~owner_mem_q;
                    end
                end

                ST_WR: begin
                    if (cnt_q == n_q - 3'd1) begin
                        state_q    <= ST_DONE;
                        ram_wr_q   <= 1'b0;
                        mem_done_q <= owner_mem_q;
                        if_done_q  <= ~owner_mem_q;
                    end else begin
                        cnt_q      <= cnt_q + 3'd1;
                        ram_a_q    <= ram_a_q + ADDR_ONE;
                        ram_dout_q <= wdata_q[{wr_idx_d, 3'b000} +: 8];
                    end
                end

                ST_DONE: begin
                    // No acceptance here; a still-high request is taken in IDLE.
                    state_q <= ST_IDLE;
                    cnt_q   <= 3'd0;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_a     = ram_a_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide RAM model (one-cycle
// read latency). Inputs change on the falling edge; outputs are checked on
// the falling edge, i.e. mid-cycle. Cycle k of a transaction is the k-th
// falling edge after the request was driven.
module tb_mem_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_count;
    int   wr_base;

    logic [7:0] ram [0:65535];

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read of the presented address, write on strobe.
    always @(posedge clk) begin
        bus.ram_din <= ram[bus.ram_a[15:0]];
        if (bus.ram_wr) begin
            ram[bus.ram_a[15:0]] = bus.ram_dout;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_if_done"},   32'(bus.if_done),   32'd0);
        check({tag, "_mem_done"},  32'(bus.mem_done),  32'd0);
        check({tag, "_if_rdata"},  bus.if_rdata,       32'd0);
        check({tag, "_mem_rdata"}, bus.mem_rdata,      32'd0);
        check({tag, "_ram_a"},     bus.ram_a,          32'd0);
        check({tag, "_ram_wr"},    32'(bus.ram_wr),    32'd0);
        check({tag, "_ram_dout"},  32'(bus.ram_dout),  32'd0);
    endtask

    initial begin
        logic [31:0] exp_a;
        checks    = 0;
        errors    = 0;
        wr_count  = 0;
        rst       = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_len   = 2'd0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.ram_din   = 8'd0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
        ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22;
        ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
        ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22;
        ram[16'h0000] = 8'hEF; ram[16'h0001] = 8'hBE;
        ram[16'h0002] = 8'hAD; ram[16'h0003] = 8'hDE;
        ram[16'h0020] = 8'hF0;
        ram[16'h2001] = 8'h5A;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Word fetch at 0x100
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i <= 4) begin
                check("fetch_ram_a", bus.ram_a, 32'(32'h100 + i - 1));
                check("fetch_ram_wr", 32'(bus.ram_wr), 32'd0);
            end
            if (i < 6) check("fetch_early_done", 32'(bus.if_done), 32'd0);
        end
        check("fetch_done", 32'(bus.if_done), 32'd1);
        check("fetch_rdata", bus.if_rdata, 32'h00000513);
        check("fetch_no_mem_done", 32'(bus.mem_done), 32'd0);
        bus.if_req = 1'b0;
        $display("txn fetch addr=0x00000100 rdata=0x%08h", bus.if_rdata);
        @(negedge clk);
        check("fetch_done_one_cycle", 32'(bus.if_done), 32'd0);
        check("fetch_rdata_hold", bus.if_rdata, 32'h00000513);

        // Abandoned fetch at 0x200: request dropped in cycle 2
        bus.if_addr = 32'h200;
        bus.if_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.if_req = 1'b0;
        check("abandon_rdata_hold", bus.if_rdata, 32'h00000513);
        for (int i = 3; i <= 5; i++) begin
            @(negedge clk);
            check("abandon_early_done", 32'(bus.if_done), 32'd0);
        end
        @(negedge clk);
        check("abandon_done", 32'(bus.if_done), 32'd1);
        check("abandon_rdata", bus.if_rdata, 32'h44332211);
        $display("txn abandoned fetch addr=0x00000200 rdata=0x%08h", bus.if_rdata);
        @(negedge clk);
        check("abandon_done_one_cycle", 32'(bus.if_done), 32'd0);

        // Asynchronous reset between clock edges clears all outputs
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        $display("txn async reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Word load wrapping past the top of the address space
        bus.mem_addr = 32'hFFFF_FFFE;
        bus.mem_len  = 2'd2;
        bus.mem_we   = 1'b0;
        bus.mem_req  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            exp_a = 32'hFFFF_FFFE + 32'(i - 1);
            if (i <= 4) check("wrap_ram_a", bus.ram_a, exp_a);
            if (i == 5) check("wrap_early_done", 32'(bus.mem_done), 32'd0);
        end
        @(negedge clk);
        check("wrap_done", 32'(bus.mem_done), 32'd1);
        check("wrap_rdata", bus.mem_rdata, 32'hBEEF2211);
        check("wrap_no_if_done", 32'(bus.if_done), 32'd0);
        bus.mem_req = 1'b0;
        $display("txn wrap load addr=0xfffffffe rdata=0x%08h", bus.mem_rdata);
        @(negedge clk);

        // Collision: load/store wins, fetch follows after DONE
        bus.if_addr  = 32'h0;
        bus.if_req   = 1'b1;
        bus.mem_addr = 32'h20;
        bus.mem_len  = 2'd0;
        bus.mem_we   = 1'b0;
        bus.mem_req  = 1'b1;
        @(negedge clk);
        check("coll_ram_a", bus.ram_a, 32'h20);
        @(negedge clk);
        check("coll_early_done", 32'(bus.mem_done), 32'd0);
        @(negedge clk);
        check("coll_mem_done", 32'(bus.mem_done), 32'd1);
        check("coll_mem_rdata", bus.mem_rdata, 32'h000000F0);
        check("coll_if_waits", 32'(bus.if_done), 32'd0);
        bus.mem_req = 1'b0;
        $display("txn collision load addr=0x00000020 rdata=0x%08h", bus.mem_rdata);
        for (int c = 4; c <= 9; c++) begin
            @(negedge clk);
            check("coll_if_pending", 32'(bus.if_done), 32'd0);
            check("coll_mem_quiet", 32'(bus.mem_done), 32'd0);
            if (c == 5) check("coll_if_ram_a", bus.ram_a, 32'h0);
        end
        @(negedge clk);
        check("coll_if_done", 32'(bus.if_done), 32'd1);
        check("coll_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        bus.if_req = 1'b0;
        $display("txn collision fetch addr=0x00000000 rdata=0x%08h", bus.if_rdata);
        @(negedge clk);

        // Half store straddling 0x1FFF/0x2000
        bus.mem_addr  = 32'h1FFF;
        bus.mem_len   = 2'd1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = 32'hAABBCCDD;
        bus.mem_req   = 1'b1;
        @(negedge clk);
        check("hst_c1_wr", 32'(bus.ram_wr), 32'd1);
        check("hst_c1_a", bus.ram_a, 32'h1FFF);
        check("hst_c1_dout", 32'(bus.ram_dout), 32'hDD);
        @(negedge clk);
        check("hst_c2_wr", 32'(bus.ram_wr), 32'd1);
        check("hst_c2_a", bus.ram_a, 32'h2000);
        check("hst_c2_dout", 32'(bus.ram_dout), 32'hCC);
        check("hst_c2_done", 32'(bus.mem_done), 32'd0);
        @(negedge clk);
        check("hst_done", 32'(bus.mem_done), 32'd1);
        check("hst_wr_off", 32'(bus.ram_wr), 32'd0);
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        check("hst_ram_1fff", 32'(ram[16'h1FFF]), 32'hDD);
        check("hst_ram_2000", 32'(ram[16'h2000]), 32'hCC);
        check("hst_ram_2001", 32'(ram[16'h2001]), 32'h5A);
        $display("txn half store addr=0x00001fff wdata=0xaabbccdd");
        @(negedge clk);

        // Half load back from 0x1FFF
        bus.mem_addr = 32'h1FFF;
        bus.mem_len  = 2'd1;
        bus.mem_req  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("hld_early_done", 32'(bus.mem_done), 32'd0);
        end
        @(negedge clk);
        check("hld_done", 32'(bus.mem_done), 32'd1);
        check("hld_rdata", bus.mem_rdata, 32'h0000CCDD);
        bus.mem_req = 1'b0;
        $display("txn half load addr=0x00001fff rdata=0x%08h", bus.mem_rdata);
        @(negedge clk);

        // Reset in cycle 2 of a word store
        wr_base       = wr_count;
        bus.mem_addr  = 32'h300;
        bus.mem_len   = 2'd2;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = 32'h44332211;
        bus.mem_req   = 1'b1;
        @(negedge clk);
        check("rstw_c1_wr", 32'(bus.ram_wr), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw_wr_drop", 32'(bus.ram_wr), 32'd0);
        check("rstw_ram_a", bus.ram_a, 32'd0);
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rstw_no_done", 32'(bus.mem_done), 32'd0);
            check("rstw_no_wr", 32'(bus.ram_wr), 32'd0);
        end
        check("rstw_write_count", 32'(wr_count - wr_base), 32'd1);
        check("rstw_ram_300", 32'(ram[16'h0300]), 32'h11);
        check("rstw_ram_301", 32'(ram[16'h0301]), 32'h00);
        $display("txn reset during word store addr=0x00000300");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
